// File: rtl/dip_result_collector.sv
// dip_result_collector
// Collects N consecutive N-wide result rows from the DiP array's bottom PE row
// into an N x N tile. Two tile banks are used ping-pong style so that filling
// one bank and draining the other over valid/ready can overlap.
module dip_result_collector #(
    parameter int N    = 4,
    parameter bit RELU = 1'b0,
    localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [N-1:0][23:0]   psum_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0][23:0]   out_row,
    output logic [IW-1:0]        out_row_idx,
    output logic                 out_last,
    output logic                 overflow,
    output logic                 busy
);

    // Write-side and read-side pointers, per-bank full flags, sticky drop flag
    logic                 wr_bank_r;
    logic [IW-1:0]        wr_row_r;
    logic                 rd_bank_r;
    logic [IW-1:0]        rd_row_r;
    logic [1:0]           full_r;
    logic                 overflow_r;

    // Tile storage; contents are deliberately not reset
    logic [N-1:0][23:0]   mem_r [2][N];

    logic                 wr_en_s;
    logic                 drop_s;
    logic                 rd_fire_s;
    logic                 wr_last_s;
    logic                 rd_last_s;
    logic [1:0]           full_next_s;

    // Optional clamp of negative (signed 24-bit) elements to zero
    function automatic logic [N-1:0][23:0] relu_row(input logic [N-1:0][23:0] row);
        logic [N-1:0][23:0] res;
        for (int k = 0; k < N; k++) begin
            if (RELU && row[k][23]) begin
                res[k] = 24'd0;
            end else begin
                res[k] = row[k];
            end
        end
        return res;
    endfunction

    // Handshake decode and next full-flag computation (all from pre-edge state)
    always_comb begin
        wr_last_s   = (wr_row_r == IW'(N - 1));
        rd_last_s   = (rd_row_r == IW'(N - 1));
        wr_en_s     = in_valid & ~clear & ~full_r[wr_bank_r];
        drop_s      = in_valid & ~clear &  full_r[wr_bank_r];
        rd_fire_s   = full_r[rd_bank_r] & out_ready & ~clear;
        full_next_s = full_r;
        // A write can only set an empty bank and a drain can only clear a
        // full one, so the two updates never target the same bank.
        if (wr_en_s && wr_last_s) begin
            full_next_s[wr_bank_r] = 1'b1;
        end else begin
            full_next_s[wr_bank_r] = full_r[wr_bank_r];
        end
        if (rd_fire_s && rd_last_s) begin
            full_next_s[rd_bank_r] = 1'b0;
        end else begin
            full_next_s[rd_bank_r] = full_next_s[rd_bank_r];
        end
    end

    // Control state: pointers, full flags and overflow, with async reset and sync clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_r  <= 1'b0;
            wr_row_r   <= '0;
            rd_bank_r  <= 1'b0;
            rd_row_r   <= '0;
            full_r     <= 2'b00;
            overflow_r <= 1'b0;
        end else if (clear) begin
            wr_bank_r  <= 1'b0;
            wr_row_r   <= '0;
            rd_bank_r  <= 1'b0;
            rd_row_r   <= '0;
            full_r     <= 2'b00;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                if (wr_last_s) begin
                    wr_row_r  <= '0;
                    wr_bank_r <= ~wr_bank_r;
                end else begin
                    wr_row_r  <= wr_row_r + IW'(1);
                end
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (rd_fire_s) begin
                if (rd_last_s) begin
                    rd_row_r  <= '0;
                    rd_bank_r <= ~rd_bank_r;
                end else begin
                    rd_row_r  <= rd_row_r + IW'(1);
                end
            end
            full_r <= full_next_s;
        end
    end

    // Row capture into the bank/row currently being filled
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_bank_r][wr_row_r] <= relu_row(psum_in);
        end
    end

    assign out_valid   = full_r[rd_bank_r];
    assign out_row     = mem_r[rd_bank_r][rd_row_r];
    assign out_row_idx = rd_row_r;
    assign out_last    = full_r[rd_bank_r] & rd_last_s;
    assign overflow    = overflow_r;
    assign busy        = full_r[0] | full_r[1] | (wr_row_r != '0);

endmodule

// File: tb/tb_dip_result_collector.sv
// Bench for dip_result_collector: two instances (RELU=0 and RELU=1) share the
// same stimulus and are compared every cycle against a queue-based tile model.
module tb_dip_result_collector;

    localparam int N  = 4;
    localparam int IW = 2;

    typedef logic [N-1:0][23:0] row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    row_t psum_in = '0;

    logic          ov0, ol0, of0, b0;
    logic          ov1, ol1, of1, b1;
    row_t          or0, or1;
    logic [IW-1:0] oi0, oi1;

    int total = 0;
    int bad   = 0;

    // Model: completed-but-undrained rows in order, rows of the tile being
    // collected, rows already drained from the head tile, sticky overflow.
    row_t pend[$];
    row_t part[$];
    int   m_idx = 0;
    bit   m_ovf = 1'b0;
    bit   chk_en = 1'b0;

    dip_result_collector #(.N(N), .RELU(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .psum_in(psum_in), .out_valid(ov0), .out_ready(out_ready),
        .out_row(or0), .out_row_idx(oi0), .out_last(ol0),
        .overflow(of0), .busy(b0)
    );

    dip_result_collector #(.N(N), .RELU(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .psum_in(psum_in), .out_valid(ov1), .out_ready(out_ready),
        .out_row(or1), .out_row_idx(oi1), .out_last(ol1),
        .overflow(of1), .busy(b1)
    );

    always #5 clk = ~clk;

    function automatic row_t relu_row(input row_t r);
        row_t o;
        for (int k = 0; k < N; k++) o[k] = r[k][23] ? 24'd0 : r[k];
        return o;
    endfunction

    function automatic row_t mk_row(input int r);
        row_t o;
        for (int k = 0; k < N; k++) o[k] = 24'(16 * r + k);
        return o;
    endfunction

    function automatic row_t rnd_row();
        row_t o;
        for (int k = 0; k < N; k++) o[k] = 24'($urandom);
        return o;
    endfunction

    function automatic int tiles_held();
        return (pend.size() + m_idx) / N;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        pend.delete();
        part.delete();
        m_idx = 0;
        m_ovf = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_update(input bit iv, input row_t d, input bit rdy, input bit clr);
        bit fire;
        bit acc;
        fire = (pend.size() > 0) && rdy;
        acc  = iv && (tiles_held() < 2);
        if (clr) begin
            model_clear();
        end else begin
            if (iv && !acc) m_ovf = 1'b1;
            if (acc) begin
                part.push_back(d);
                if (part.size() == N) begin
                    foreach (part[i]) pend.push_back(part[i]);
                    part.delete();
                end
            end
            if (fire) begin
                void'(pend.pop_front());
                m_idx++;
                if (m_idx == N) m_idx = 0;
            end
        end
    endtask

    task automatic step(input bit iv, input row_t d, input bit rdy, input bit clr);
        in_valid  = iv;
        psum_in   = d;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        model_update(iv, d, rdy, clr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_async_valid", ov0, 1'b0);
        chk("rst_async_busy", b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        bit   v;
        row_t h;
        if (chk_en) begin
            v = (pend.size() > 0);
            chk("out_valid0", ov0, v);
            chk("out_valid1", ov1, v);
            chk("busy0", b0, (tiles_held() > 0) || (part.size() != 0));
            chk("busy1", b1, (tiles_held() > 0) || (part.size() != 0));
            chk("overflow0", of0, m_ovf);
            chk("overflow1", of1, m_ovf);
            chk("out_last0", ol0, v && (m_idx == N - 1));
            chk("out_last1", ol1, v && (m_idx == N - 1));
            if (v) begin
                h = pend[0];
                chk("out_row_idx0", oi0, m_idx);
                chk("out_row_idx1", oi1, m_idx);
                chk("out_row0", or0, h);
                chk("out_row1", or1, relu_row(h));
            end
        end
    end

    initial begin
        row_t z;
        row_t rp;
        row_t exp_relu;
        z = '0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_valid", ov0, 1'b0);
        chk("reset_idx", oi0, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic tile, latency and ordering
        for (int r = 0; r < N; r++) begin
            if (r == N - 1) chk("t1_not_yet_valid", ov0, 1'b0);
            step(1'b1, mk_row(r), 1'b1, 1'b0);
        end
        chk("t1_valid_after_row3", ov0, 1'b1);
        chk("t1_r0k3", or0[3], 24'h000003);
        step(1'b0, z, 1'b1, 1'b0);
        chk("t1_idx1", oi0, 2'd1);
        chk("t1_r1k2", or0[2], 24'h000012);
        step(1'b0, z, 1'b1, 1'b0);
        step(1'b0, z, 1'b1, 1'b0);
        chk("t1_last", ol0, 1'b1);
        chk("t1_r3k1", or0[1], 24'h000031);
        step(1'b0, z, 1'b1, 1'b0);
        chk("t1_drained", ov0, 1'b0);

        // Back-pressure
        for (int r = 0; r < N; r++) step(1'b1, mk_row(r + 4), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, z, 1'b0, 1'b0);
        for (int i = 0; i < 2 * N; i++) step(1'b0, z, (i % 2) == 0, 1'b0);

        // Ping-pong and overflow
        for (int r = 0; r < 9; r++) step(1'b1, mk_row(r + 8), 1'b0, 1'b0);
        chk("t3_overflow", of0, 1'b1);
        for (int i = 0; i < 2 * N + 2; i++) step(1'b0, z, 1'b1, 1'b0);
        chk("t3_overflow_sticky", of0, 1'b1);

        // Same-edge drain-complete and write to that bank
        step(1'b0, z, 1'b0, 1'b1);
        chk("t4_clear_ovf", of0, 1'b0);
        for (int r = 0; r < 2 * N; r++) step(1'b1, mk_row(r + 32), 1'b0, 1'b0);
        for (int i = 0; i < N - 1; i++) step(1'b0, z, 1'b1, 1'b0);
        step(1'b1, mk_row(60), 1'b1, 1'b0);
        chk("t4_dropped", of0, 1'b1);
        chk("t4_bank1_valid", ov0, 1'b1);
        step(1'b1, mk_row(61), 1'b0, 1'b0);
        for (int r = 0; r < N - 1; r++) step(1'b1, mk_row(62 + r), 1'b1, 1'b0);
        for (int i = 0; i < N + 2; i++) step(1'b0, z, 1'b1, 1'b0);

        // ReLU boundary values
        step(1'b0, z, 1'b0, 1'b1);
        rp[0] = 24'hFFFFFF; rp[1] = 24'h800000; rp[2] = 24'h7FFFFF; rp[3] = 24'h000000;
        exp_relu[0] = 24'h000000; exp_relu[1] = 24'h000000;
        exp_relu[2] = 24'h7FFFFF; exp_relu[3] = 24'h000000;
        step(1'b1, rp, 1'b0, 1'b0);
        for (int r = 1; r < N; r++) step(1'b1, mk_row(r), 1'b0, 1'b0);
        chk("t5_relu_row", or1, exp_relu);
        chk("t5_raw_row", or0, rp);
        for (int i = 0; i < N; i++) step(1'b0, z, 1'b1, 1'b0);

        // clear after partial tile, clear with one bank full, reset mid-tile
        step(1'b1, mk_row(1), 1'b0, 1'b0);
        step(1'b1, mk_row(2), 1'b0, 1'b0);
        step(1'b0, z, 1'b0, 1'b1);
        chk("t6_busy_after_clear", b0, 1'b0);
        for (int r = 0; r < N + 1; r++) step(1'b1, mk_row(r + 70), 1'b0, 1'b0);
        step(1'b1, mk_row(99), 1'b1, 1'b1);
        chk("t6_valid_after_clear", ov0, 1'b0);
        chk("t6_busy_after_clear2", b1, 1'b0);
        for (int r = 0; r < N; r++) step(1'b1, mk_row(r + 80), 1'b1, 1'b0);
        for (int i = 0; i < N; i++) step(1'b0, z, 1'b1, 1'b0);
        for (int r = 0; r < N + 2; r++) step(1'b1, mk_row(r + 90), 1'b0, 1'b0);
        do_reset();
        chk("t6_idx_after_reset", oi0, 2'd0);
        for (int r = 0; r < N; r++) step(1'b1, mk_row(r + 100), 1'b1, 1'b0);
        for (int i = 0; i < N; i++) step(1'b0, z, 1'b1, 1'b0);

        // Randomized traffic with occasional clears
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rnd_row(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 199) == 0);
        end
        // Drain whatever remains
        for (int i = 0; i < 2 * N + 2; i++) step(1'b0, z, 1'b1, 1'b0);
        chk("final_empty", ov0, 1'b0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dip_result_collector.md
Name: dip_result_collector

Overview:
Downstream stage of the DiP systolic array. Captures the N-wide, 24-bit partial-sum row the array's bottom PE row emits each valid cycle and assembles N consecutive rows into an N×N result tile. Tiles are held in a two-bank ping-pong buffer, so the array can keep producing while the previous tile drains row by row to memory/host over a valid/ready interface.

Parameters:
N, 4, array dimension; elements per row and rows per tile.
RELU, 0, 1 = clamp negative (signed 24-bit) results to 0 at capture; 0 = pass through unchanged.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
clear  input  1  synchronous flush of counters, flags and overflow.
in_valid  input  1  psum_in holds a valid result row this cycle.
psum_in  input  [23:0][N-1:0]  result row from the array; element k = column k.
out_valid  output  1  out_row holds a valid stored row.
out_ready  input  1  consumer accepts out_row.
out_row  output  [23:0][N-1:0]  drained row.
out_row_idx  output  $clog2(N)  row index within the tile being drained.
out_last  output  1  high with the final row (idx N-1) of a tile.
overflow  output  1  sticky; a valid input row was dropped.
busy  output  1  any bank full, or a tile partially collected.

Behaviour:
- Reset (rst_n low, async): wr_bank=0, wr_row=0, rd_bank=0, rd_row=0, full[1:0]=0, overflow=0. Outputs: out_valid=0, out_last=0, out_row_idx=0, busy=0, overflow=0. out_row shows bank 0 row 0 and is don't-care while out_valid=0. Buffer contents are not reset.
- Capture, on each posedge with in_valid=1:
  - If full[wr_bank]=0: store psum_in (after optional ReLU) at bank[wr_bank][wr_row].
  - If wr_row=N-1: set full[wr_bank], wr_row←0, toggle wr_bank. Otherwise wr_row++.
  - If full[wr_bank]=1: drop the row, leave wr_row unchanged, set overflow.
- ReLU when RELU=1: element with bit23=1 is stored as 0. Otherwise stored bit-exact. No width change.
- Drain:
  - out_valid = full[rd_bank], combinational from registered state.
  - out_row = bank[rd_bank][rd_row]; out_row_idx = rd_row.
  - out_last = out_valid and (rd_row=N-1).
  - On out_valid and out_ready: rd_row++. If it was the last row: clear full[rd_bank], rd_row←0, toggle rd_bank.
  - out_row, out_row_idx and out_last hold stable while out_valid and not out_ready.
- Latency: the N-th accepted row's edge sets full, so out_valid rises in the following cycle. With out_ready held high, a tile drains in N consecutive cycles.
- Throughput: continuous in_valid with continuous out_ready never overflows, because fill and drain use opposite banks.
- Simultaneous events:
  - Drain-complete of bank B and an in_valid targeting full bank B in the same cycle: the full check uses pre-edge state, so the row is dropped and overflow is set.
  - Write to one bank and read from the other in the same cycle is legal and independent.
- clear (sync, priority over capture and drain):
  - Counters, banks pointers and full flags return to reset values; overflow←0.
  - Any in_valid or handshake in the clear cycle is ignored.
- busy = full[0] | full[1] | (wr_row≠0).
- rst_n asserted mid-tile: all progress is lost immediately. out_valid drops asynchronously.

Test Plan:
1. N=4, RELU=0: 4 rows with element value 16·r+k (r=row, k=column), out_ready=1 → out_valid rises one cycle after row 3; out_row_idx 0,1,2,3 on consecutive cycles; out_last only at idx 3; data matches bit-exact.
2. Back-pressure: fill a tile, hold out_ready=0 for 5 cycles, then pulse it every other cycle → out_row stable while stalled; each row delivered exactly once, in order.
3. Ping-pong/overflow: out_ready=0, send 9 rows → rows 0–7 fill both banks; 9th dropped, overflow=1 and stays 1. Drain both tiles → 8 rows correct, bank 0 tile first.
4. Same-edge corner: both banks full; assert out_ready on bank 0's last row together with in_valid → that input is dropped, overflow=1; the next in_valid lands in bank 0 row 0.
5. RELU=1: inputs 24'hFFFFFF, 24'h800000, 24'h7FFFFF, 0 → stored 0, 0, 24'h7FFFFF, 0.
6. clear after 2 rows (and again with one bank full) → busy=0, out_valid=0, overflow=0. A following 4-row tile collects from row 0 of bank 0. Repeat with rst_n pulsed mid-tile → same result.
